// File: rtl/ctrl_pipe_unit.sv
`default_nettype none
// ==========================================================================
// ctrl_pipe_unit - MIPS main control decode with ID/EX, EX/MEM, MEM/WB bundles
// Revision: 1.0
// ==========================================================================
module ctrl_pipe_unit #(
  parameter int OP_W        = 6,
  parameter int REG_AW      = 5,
  parameter bit HAZARD_EN   = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_W-1:0]        opcode,
  input  logic                   id_valid,
  input  logic [REG_AW-1:0]      id_rs,
  input  logic [REG_AW-1:0]      id_rt,
  input  logic                   flush,
  output logic [1:0]             ex_wb,
  output logic [2:0]             ex_m,
  output logic [3:0]             ex_ex,
  output logic [REG_AW-1:0]      ex_rt,
  output logic [1:0]             mem_wb,
  output logic [2:0]             mem_m,
  output logic [1:0]             wb_wb,
  output logic                   illegal,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);

  logic [1:0]             dec_wb;
  logic [2:0]             dec_m;
  logic [3:0]             dec_ex;
  logic                   dec_ill;
  logic                   hazard_w;

  logic [1:0]             ex_wb_q,  ex_wb_d;
  logic [2:0]             ex_m_q,   ex_m_d;
  logic [3:0]             ex_ex_q,  ex_ex_d;
  logic [REG_AW-1:0]      ex_rt_q,  ex_rt_d;
  logic                   ill_q,    ill_d;
  logic [1:0]             mem_wb_q;
  logic [2:0]             mem_m_q;
  logic [1:0]             wb_wb_q;
  logic [STALL_CNT_W-1:0] cnt_q,    cnt_d;

  always_comb begin
    dec_wb  = 2'b00;
    dec_m   = 3'b000;
    dec_ex  = 4'b0000;
    dec_ill = 1'b0;
    case (opcode)
      OP_RTYPE: begin dec_wb = 2'b10; dec_m = 3'b000; dec_ex = 4'b1100; end
      OP_LW:    begin dec_wb = 2'b11; dec_m = 3'b010; dec_ex = 4'b0001; end
      OP_SW:    begin dec_wb = 2'b00; dec_m = 3'b001; dec_ex = 4'b0001; end
      OP_BEQ:   begin dec_wb = 2'b00; dec_m = 3'b100; dec_ex = 4'b0010; end
      OP_ADDI:  begin dec_wb = 2'b10; dec_m = 3'b000; dec_ex = 4'b0001; end
      default:  dec_ill = 1'b1;
    endcase
  end

  // A load in EX whose destination (never $zero) feeds the ID instruction.
  assign hazard_w = ex_m_q[1] && (ex_rt_q != '0) &&
                    ((ex_rt_q == id_rs) || (ex_rt_q == id_rt));
  assign stall    = HAZARD_EN && id_valid && !flush && !rst && hazard_w;

  always_comb begin
    ex_wb_d = 2'b00;
    ex_m_d  = 3'b000;
    ex_ex_d = 4'b0000;
    ex_rt_d = '0;
    ill_d   = 1'b0;
    if (id_valid && !flush && !stall) begin
      ex_wb_d = dec_wb;
      ex_m_d  = dec_m;
      ex_ex_d = dec_ex;
      ex_rt_d = id_rt;
      ill_d   = dec_ill;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_wb_q  <= 2'b00;
      ex_m_q   <= 3'b000;
      ex_ex_q  <= 4'b0000;
      ex_rt_q  <= '0;
      ill_q    <= 1'b0;
      mem_wb_q <= 2'b00;
      mem_m_q  <= 3'b000;
      wb_wb_q  <= 2'b00;
      cnt_q    <= '0;
    end else begin
      ex_wb_q  <= ex_wb_d;
      ex_m_q   <= ex_m_d;
      ex_ex_q  <= ex_ex_d;
      ex_rt_q  <= ex_rt_d;
      ill_q    <= ill_d;
      mem_wb_q <= ex_wb_q;
      mem_m_q  <= ex_m_q;
      wb_wb_q  <= mem_wb_q;
      cnt_q    <= cnt_d;
    end
  end

  assign ex_wb     = ex_wb_q;
  assign ex_m      = ex_m_q;
  assign ex_ex     = ex_ex_q;
  assign ex_rt     = ex_rt_q;
  assign illegal   = ill_q;
  assign mem_wb    = mem_wb_q;
  assign mem_m     = mem_m_q;
  assign wb_wb     = wb_wb_q;
  assign stall_cnt = cnt_q;

endmodule
`default_nettype wire
